// File: rtl/seq_store.sv
// seq_store -- parametrised symbol-sequence store with a playback FSM.
//
// Holds up to DEPTH symbols of SYM_W bits plus a length counter. The store is
// filled either by bulk-loading the whole vector or by appending one symbol
// per round. The playback FSM (IDLE/PLAY) then replays the stored symbols one
// at a time for the display or compare logic.
//
// Optional feature macro: SEQ_STORE_OVF_EN
//   Defined   -> adds sticky output 'ovf', set by an append while full and
//                cleared only by clr or R.
//   Undefined -> no 'ovf' port; an append while full is silently ignored.
//
// Ports:
//   clk       rising-edge clock
//   R         asynchronous active-high reset
//   E         enable; when low nothing changes (except through R)
//   clr       synchronous clear of sequence and playback
//   load      bulk-load 'data' into q (len becomes DEPTH, playback aborted)
//   data      bulk-load vector, slot i = data[i*SYM_W +: SYM_W]
//   app       append sym_in at slot len (ignored when full)
//   sym_in    symbol to append
//   rd_start  start/restart playback at slot 0
//   rd_next   advance playback
//   q         stored sequence, slot 0 in the low bits
//   q_head    slot DEPTH-1 (top SYM_W bits of q)
//   len       number of valid symbols
//   full      len == DEPTH
//   rd_valid  playback active
//   rd_sym    symbol at the playback pointer (0 when idle)
//   rd_last   playback is at the final valid symbol
//   ovf       (SEQ_STORE_OVF_EN only) sticky append-while-full flag

module seq_store #(
  parameter int SYM_W = 4,
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input  logic                   clk,
  input  logic                   R,
  input  logic                   E,
  input  logic                   clr,
  input  logic                   load,
  input  logic [SYM_W*DEPTH-1:0] data,
  input  logic                   app,
  input  logic [SYM_W-1:0]       sym_in,
  input  logic                   rd_start,
  input  logic                   rd_next,
  output logic [SYM_W*DEPTH-1:0] q,
  output logic [SYM_W-1:0]       q_head,
  output logic [LEN_W-1:0]       len,
  output logic                   full,
  output logic                   rd_valid,
  output logic [SYM_W-1:0]       rd_sym,
  output logic                   rd_last
`ifdef SEQ_STORE_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int QW = SYM_W * DEPTH;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] rd_ptr, ptr_next;
  logic [QW-1:0]    q_next;
  logic [LEN_W-1:0] len_next;
  logic             ptr_at_last;

  assign full        = (len == LEN_FULL);
  assign q_head      = q[QW-1 -: SYM_W];
  // In PLAY len is never 0 (clr/load/reset always force IDLE), so len-1 is safe.
  assign ptr_at_last = (rd_ptr == (len - LEN_W'(1)));
  assign rd_valid    = (state == PLAY);
  assign rd_last     = (state == PLAY) && ptr_at_last;

  // Write side: clr beats load beats append. The append slot is picked by
  // comparing each slot index against len rather than a variable part-select.
  always_comb begin
    q_next   = q;
    len_next = len;
    if (clr) begin
      q_next   = '0;
      len_next = '0;
    end else if (load) begin
      q_next   = data;
      len_next = LEN_FULL;
    end else if (app && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (LEN_W'(i) == len) begin
          q_next[i*SYM_W +: SYM_W] = sym_in;
        end
      end
      len_next = len + LEN_W'(1);
    end
  end

  // Playback next-state logic. clr and load both abort playback; otherwise
  // rd_start has priority over rd_next. Reading the pre-append len here means
  // an append during PLAY extends playback from the following cycle.
  always_comb begin
    state_next = state;
    ptr_next   = rd_ptr;
    if (clr || load) begin
      state_next = IDLE;
      ptr_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_start && (len != '0)) begin
            state_next = PLAY;
            ptr_next   = '0;
          end
        end
        PLAY: begin
          if (rd_start) begin
            ptr_next = '0;
          end else if (rd_next) begin
            if (ptr_at_last) begin
              state_next = IDLE;
              ptr_next   = '0;
            end else begin
              ptr_next = rd_ptr + LEN_W'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      endcase
    end
  end

  // Registers; E low freezes the whole block.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      q      <= '0;
      len    <= '0;
      state  <= IDLE;
      rd_ptr <= '0;
    end else if (E) begin
      q      <= q_next;
      len    <= len_next;
      state  <= state_next;
      rd_ptr <= ptr_next;
    end
  end

  // Playback symbol mux; reads 0 whenever playback is inactive.
  always_comb begin
    rd_sym = '0;
    if (state == PLAY) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (LEN_W'(i) == rd_ptr) begin
          rd_sym = q[i*SYM_W +: SYM_W];
        end
      end
    end
  end

`ifdef SEQ_STORE_OVF_EN
  // Sticky overflow flag: only clr or R clear it, load leaves it alone.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      ovf <= 1'b0;
    end else if (E) begin
      if (clr) begin
        ovf <= 1'b0;
      end else if (!load && app && full) begin
        ovf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_store.sv
// tb_seq_store -- directed self-checking bench for seq_store.
//
// Inputs change 1 time unit after a rising edge and outputs are sampled just
// after the following edge, so every check sees the registered result of the
// cycle that was just driven.

module tb_seq_store;

  localparam int SYM_W = 4;
  localparam int DEPTH = 16;
  localparam int LEN_W = 5;
  localparam int QW    = SYM_W * DEPTH;

  logic             clk;
  logic             R;
  logic             E;
  logic             clr;
  logic             load;
  logic [QW-1:0]    data;
  logic             app;
  logic [SYM_W-1:0] sym_in;
  logic             rd_start;
  logic             rd_next;
  logic [QW-1:0]    q;
  logic [SYM_W-1:0] q_head;
  logic [LEN_W-1:0] len;
  logic             full;
  logic             rd_valid;
  logic [SYM_W-1:0] rd_sym;
  logic             rd_last;
`ifdef SEQ_STORE_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [QW-1:0] LOAD_VEC = 64'hF123_4567_89AB_CDEF;

  seq_store #(
    .SYM_W(SYM_W),
    .DEPTH(DEPTH),
    .LEN_W(LEN_W)
  ) dut (
    .clk      (clk),
    .R        (R),
    .E        (E),
    .clr      (clr),
    .load     (load),
    .data     (data),
    .app      (app),
    .sym_in   (sym_in),
    .rd_start (rd_start),
    .rd_next  (rd_next),
    .q        (q),
    .q_head   (q_head),
    .len      (len),
    .full     (full),
    .rd_valid (rd_valid),
    .rd_sym   (rd_sym),
    .rd_last  (rd_last)
`ifdef SEQ_STORE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then step 1 unit off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of control inputs, then clock it in.
  task automatic applyStimulus(input logic e, input logic c, input logic ld,
                               input logic a, input logic [SYM_W-1:0] s,
                               input logic st, input logic nx);
    E        = e;
    clr      = c;
    load     = ld;
    app      = a;
    sym_in   = s;
    rd_start = st;
    rd_next  = nx;
    tick();
  endtask

  initial begin
    R = 1'b1; E = 1'b0; clr = 1'b0; load = 1'b0; data = '0;
    app = 1'b0; sym_in = '0; rd_start = 1'b0; rd_next = 1'b0;

    // Reset state
    #12;
    R = 1'b0;
    tick();
    checkOutput("reset_q", q, 64'h0);
    checkOutput("reset_len", 64'(len), 64'd0);
    checkOutput("reset_full", 64'(full), 64'd0);
    checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("reset_q_head", 64'(q_head), 64'd0);
    checkOutput("reset_rd_sym", 64'(rd_sym), 64'd0);
`ifdef SEQ_STORE_OVF_EN
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
`endif

    // Append 1,2,3
    applyStimulus(1, 0, 0, 1, 4'h1, 0, 0);
    checkOutput("app1_len", 64'(len), 64'd1);
    applyStimulus(1, 0, 0, 1, 4'h2, 0, 0);
    applyStimulus(1, 0, 0, 1, 4'h3, 0, 0);
    checkOutput("app3_len", 64'(len), 64'd3);
    checkOutput("app3_q", q, 64'h321);
    checkOutput("app3_q_head", 64'(q_head), 64'd0);
    checkOutput("app3_full", 64'(full), 64'd0);

    // Playback 1,2,3 then end
    applyStimulus(1, 0, 0, 0, 4'h0, 1, 0);
    checkOutput("play0_valid", 64'(rd_valid), 64'd1);
    checkOutput("play0_sym", 64'(rd_sym), 64'h1);
    checkOutput("play0_last", 64'(rd_last), 64'd0);
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 1);
    checkOutput("play1_sym", 64'(rd_sym), 64'h2);
    checkOutput("play1_last", 64'(rd_last), 64'd0);
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 1);
    checkOutput("play2_sym", 64'(rd_sym), 64'h3);
    checkOutput("play2_last", 64'(rd_last), 64'd1);
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 1);
    checkOutput("play_end_valid", 64'(rd_valid), 64'd0);
    checkOutput("play_end_sym", 64'(rd_sym), 64'd0);
    checkOutput("play_end_last", 64'(rd_last), 64'd0);

    // Next while IDLE is ignored
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 1);
    checkOutput("idle_next_valid", 64'(rd_valid), 64'd0);

    // Bulk load, then append while full
    data = LOAD_VEC;
    applyStimulus(1, 0, 1, 0, 4'h0, 0, 0);
    checkOutput("load_q", q, LOAD_VEC);
    checkOutput("load_len", 64'(len), 64'd16);
    checkOutput("load_full", 64'(full), 64'd1);
    checkOutput("load_q_head", 64'(q_head), 64'hF);
    applyStimulus(1, 0, 0, 1, 4'h5, 0, 0);
    checkOutput("appfull_q", q, LOAD_VEC);
    checkOutput("appfull_len", 64'(len), 64'd16);
`ifdef SEQ_STORE_OVF_EN
    checkOutput("appfull_ovf", 64'(ovf), 64'd1);
`endif
    data = 64'h0123_4567_89AB_CDEF;
    applyStimulus(1, 0, 1, 0, 4'h0, 0, 0);
    checkOutput("reload_q_head", 64'(q_head), 64'h0);
`ifdef SEQ_STORE_OVF_EN
    checkOutput("reload_ovf_kept", 64'(ovf), 64'd1);
`endif
    // clr beats simultaneous load and append
    applyStimulus(1, 1, 1, 1, 4'h9, 0, 0);
    checkOutput("clr_q", q, 64'h0);
    checkOutput("clr_len", 64'(len), 64'd0);
    checkOutput("clr_full", 64'(full), 64'd0);
`ifdef SEQ_STORE_OVF_EN
    checkOutput("clr_ovf", 64'(ovf), 64'd0);
`endif

    // Playback of 1,2 extended by an append mid-play
    applyStimulus(1, 0, 0, 1, 4'h1, 0, 0);
    applyStimulus(1, 0, 0, 1, 4'h2, 0, 0);
    applyStimulus(1, 0, 0, 0, 4'h0, 1, 0);
    checkOutput("ext0_sym", 64'(rd_sym), 64'h1);
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 1);
    checkOutput("ext1_sym", 64'(rd_sym), 64'h2);
    checkOutput("ext1_last_before_app", 64'(rd_last), 64'd1);
    applyStimulus(1, 0, 0, 1, 4'h7, 0, 0);
    checkOutput("ext_app_len", 64'(len), 64'd3);
    checkOutput("ext_app_last", 64'(rd_last), 64'd0);
    checkOutput("ext_app_sym", 64'(rd_sym), 64'h2);
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 1);
    checkOutput("ext2_sym", 64'(rd_sym), 64'h7);
    checkOutput("ext2_last", 64'(rd_last), 64'd1);
    // rd_start wins over rd_next: restart at slot 0
    applyStimulus(1, 0, 0, 0, 4'h0, 1, 1);
    checkOutput("restart_valid", 64'(rd_valid), 64'd1);
    checkOutput("restart_sym", 64'(rd_sym), 64'h1);
    // load during PLAY aborts playback
    data = LOAD_VEC;
    applyStimulus(1, 0, 1, 0, 4'h0, 0, 0);
    checkOutput("load_abort_valid", 64'(rd_valid), 64'd0);
    checkOutput("load_abort_len", 64'(len), 64'd16);

    // E=0 freezes a pending playback
    applyStimulus(1, 1, 0, 0, 4'h0, 0, 0);
    applyStimulus(1, 0, 0, 1, 4'hA, 0, 0);
    applyStimulus(1, 0, 0, 1, 4'hB, 0, 0);
    applyStimulus(1, 0, 0, 0, 4'h0, 1, 0);
    applyStimulus(0, 0, 0, 1, 4'hC, 0, 1);
    applyStimulus(0, 0, 0, 1, 4'hC, 0, 1);
    checkOutput("frz_len", 64'(len), 64'd2);
    checkOutput("frz_q", q, 64'hBA);
    checkOutput("frz_valid", 64'(rd_valid), 64'd1);
    checkOutput("frz_sym", 64'(rd_sym), 64'hA);
    applyStimulus(0, 1, 0, 0, 4'h0, 0, 0);
    checkOutput("frz_clr_len", 64'(len), 64'd2);

    // rd_start with empty store stays IDLE
    applyStimulus(1, 1, 0, 0, 4'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 4'h0, 1, 0);
    checkOutput("empty_start_valid", 64'(rd_valid), 64'd0);

    // Async reset mid-playback, between edges
    applyStimulus(1, 0, 0, 1, 4'h1, 0, 0);
    applyStimulus(1, 0, 0, 1, 4'h2, 0, 0);
    applyStimulus(1, 0, 0, 0, 4'h0, 1, 0);
    checkOutput("pre_rst_valid", 64'(rd_valid), 64'd1);
    #2;
    R = 1'b1;
    #1;
    checkOutput("async_rst_valid", 64'(rd_valid), 64'd0);
    checkOutput("async_rst_len", 64'(len), 64'd0);
    checkOutput("async_rst_q", q, 64'h0);
    R = 1'b0;
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 0);
    checkOutput("post_rst_valid", 64'(rd_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
